// File: rtl/spi_flash_init_seq.sv
`timescale 1ns/1ps
// rtl/spi_flash_init_seq.sv - power-on configuration sequencer for the external SPI flash
module spi_flash_init_seq #(
    parameter int          POWERUP_CYCLES    = 1000,
    parameter int          RESET_WAIT_CYCLES = 2000,
    parameter int          MAX_POLLS         = 256,
    parameter logic [7:0]  SR_VALUE          = 8'h02
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_data,
    output logic       cmd_last,
    input  logic       rsp_valid,
    input  logic [7:0] rsp_data,
    output logic       init_done,
    output logic       init_error,
    output logic       busy
);

    localparam int TMAX = (POWERUP_CYCLES > RESET_WAIT_CYCLES) ? POWERUP_CYCLES : RESET_WAIT_CYCLES;
    localparam int TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;
    localparam int PW   = $clog2(MAX_POLLS + 1);

    typedef enum logic [2:0] {
        PWR_WAIT,
        ISSUE,
        WAIT_RSP,
        RST_WAIT,
        POLL_EVAL,
        DONE,
        ERROR
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [2:0]      step;
    logic [PW-1:0]   poll_cnt;
    logic            wip_q;

    // Only the WIP flag of the status byte steers the sequence
    logic unused_rsp_bits;
    assign unused_rsp_bits = ^rsp_data[7:1];

    // Command script: {last, byte} for each step
    function automatic logic [8:0] script(input logic [2:0] s);
        case (s)
            3'd0:    script = {1'b1, 8'h66};
            3'd1:    script = {1'b1, 8'h99};
            3'd2:    script = {1'b1, 8'h06};
            3'd3:    script = {1'b0, 8'h31};
            3'd4:    script = {1'b1, SR_VALUE};
            3'd5:    script = {1'b0, 8'h05};
            default: script = {1'b1, 8'h00};
        endcase
    endfunction

    // Sequencer FSM with registered outputs; the command byte is loaded on entry to ISSUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PWR_WAIT;
            timer      <= '0;
            step       <= 3'd0;
            poll_cnt   <= '0;
            wip_q      <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_data   <= 8'h00;
            cmd_last   <= 1'b0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
            busy       <= 1'b1;
        end else begin
            case (state)
                PWR_WAIT: begin
                    if (POWERUP_CYCLES == 0 || timer == TW'(POWERUP_CYCLES - 1)) begin
                        timer                <= '0;
                        state                <= ISSUE;
                        cmd_valid            <= 1'b1;
                        {cmd_last, cmd_data} <= script(step);
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_valid) begin
                        wip_q <= rsp_data[0];
                        if (step == 3'd1) begin
                            timer <= '0;
                            state <= RST_WAIT;
                        end else if (step == 3'd6) begin
                            state <= POLL_EVAL;
                        end else begin
                            step                 <= step + 3'd1;
                            state                <= ISSUE;
                            cmd_valid            <= 1'b1;
                            {cmd_last, cmd_data} <= script(step + 3'd1);
                        end
                    end
                end
                RST_WAIT: begin
                    if (RESET_WAIT_CYCLES == 0 || timer == TW'(RESET_WAIT_CYCLES - 1)) begin
                        timer                <= '0;
                        step                 <= 3'd2;
                        state                <= ISSUE;
                        cmd_valid            <= 1'b1;
                        {cmd_last, cmd_data} <= script(3'd2);
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                POLL_EVAL: begin
                    if (!wip_q) begin
                        state     <= DONE;
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                    end else if (poll_cnt < PW'(MAX_POLLS - 1)) begin
                        poll_cnt             <= poll_cnt + PW'(1);
                        step                 <= 3'd5;
                        state                <= ISSUE;
                        cmd_valid            <= 1'b1;
                        {cmd_last, cmd_data} <= script(3'd5);
                    end else begin
                        state      <= ERROR;
                        init_error <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                DONE:    state <= DONE;
                ERROR:   state <= ERROR;
                default: state <= ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_init_seq.sv
`timescale 1ns/1ps
// tb/tb_spi_flash_init_seq.sv - directed bench for spi_flash_init_seq
module tb_spi_flash_init_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    logic [7:0] cmd_data  [2];
    logic       cmd_last  [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_data  [2];
    logic       init_done [2];
    logic       init_error[2];
    logic       busy      [2];

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;

    int         cd       [2];
    logic [7:0] rsp_d    [2];
    int         wip_left [2];
    int         bp_left  [2];
    int         bp_obs   [2];
    logic [8:0] log_mem  [2][32];
    int         log_n    [2];
    int         first_cyc[2];

    int         wip_cfg  [2];
    int         bp_cfg   [2];
    logic [7:0] busy_val [2];
    logic       spur     [2];

    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    spi_flash_init_seq #(.POWERUP_CYCLES(4), .RESET_WAIT_CYCLES(3), .MAX_POLLS(4), .SR_VALUE(8'h02)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_data(cmd_data[0]), .cmd_last(cmd_last[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
        .init_done(init_done[0]), .init_error(init_error[0]), .busy(busy[0])
    );

    spi_flash_init_seq #(.POWERUP_CYCLES(4), .RESET_WAIT_CYCLES(3), .MAX_POLLS(2), .SR_VALUE(8'h02)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_data(cmd_data[1]), .cmd_last(cmd_last[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
        .init_done(init_done[1]), .init_error(init_error[1]), .busy(busy[1])
    );

    // cycle count since reset release
    always @(posedge clk) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    // byte engine model: response two cycles after acceptance, optional backpressure on 0x31
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                cd[i] = 0; rsp_valid[i] = 1'b0; rsp_data[i] = 8'h00; cmd_ready[i] = 1'b1;
                log_n[i] = 0; first_cyc[i] = -1; bp_left[i] = bp_cfg[i]; bp_obs[i] = 0;
                wip_left[i] = wip_cfg[i]; rsp_d[i] = 8'h00;
            end else begin
                rsp_valid[i] = spur[i];
                rsp_data[i]  = 8'h00;
                if (cd[i] > 0) begin
                    cd[i] = cd[i] - 1;
                    if (cd[i] == 0) begin
                        rsp_valid[i] = 1'b1;
                        rsp_data[i]  = rsp_d[i];
                    end
                end
                if (first_cyc[i] < 0 && cmd_valid[i]) first_cyc[i] = cyc;
                cmd_ready[i] = 1'b1;
                if (bp_left[i] > 0 && cmd_valid[i] && cmd_data[i] == 8'h31) begin
                    cmd_ready[i] = 1'b0;
                    bp_left[i]   = bp_left[i] - 1;
                    if (!cmd_last[i]) bp_obs[i] = bp_obs[i] + 1;
                end
                if (cmd_valid[i] && cmd_ready[i]) begin
                    rsp_d[i] = 8'h00;
                    if (log_n[i] > 0 && log_n[i] <= 32 && log_mem[i][log_n[i]-1] == 9'h005 && wip_left[i] > 0) begin
                        rsp_d[i]    = busy_val[i];
                        wip_left[i] = wip_left[i] - 1;
                    end
                    if (log_n[i] < 32) log_mem[i][log_n[i]] = {cmd_last[i], cmd_data[i]};
                    log_n[i] = log_n[i] + 1;
                    cd[i]    = 2;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input int i, input string tag);
        check({tag, "_cmd_valid"},  32'(cmd_valid[i]),  32'd0);
        check({tag, "_cmd_data"},   32'(cmd_data[i]),   32'd0);
        check({tag, "_cmd_last"},   32'(cmd_last[i]),   32'd0);
        check({tag, "_init_done"},  32'(init_done[i]),  32'd0);
        check({tag, "_init_error"}, 32'(init_error[i]), 32'd0);
        check({tag, "_busy"},       32'(busy[i]),       32'd1);
    endtask

    task automatic check_log(input int i, input string tag);
        check({tag, "_len"}, 32'(log_n[i]), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < log_n[i] && k < 32; k++)
            check($sformatf("%s_b%0d", tag, k), 32'(log_mem[i][k]), 32'(exp_q[k]));
    endtask

    task automatic wait_end(input int i, input int budget, input string tag);
        int n = 0;
        while (!(init_done[i] || init_error[i]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(init_done[i] || init_error[i])) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic reset_release();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        busy_val = '{8'h01, 8'h03};
        wip_cfg  = '{0, 1000};
        bp_cfg   = '{0, 0};
        spur     = '{1'b0, 1'b0};

        // Run A: nominal on dut0 with spurious response in PWR_WAIT, poll timeout on dut1
        repeat (3) @(negedge clk);
        #1;
        check_reset(0, "rst0");
        check_reset(1, "rst1");
        rst_n   = 1'b1;
        spur[0] = 1'b1;
        @(negedge clk);
        #1 spur[0] = 1'b0;
        wait_end(0, 400, "runA0");
        wait_end(1, 400, "runA1");
        check("A_first_cyc0", 32'(first_cyc[0]), 32'd4);
        check("A_first_cyc1", 32'(first_cyc[1]), 32'd4);
        check("A_done0",  32'(init_done[0]),  32'd1);
        check("A_err0",   32'(init_error[0]), 32'd0);
        check("A_busy0",  32'(busy[0]),       32'd0);
        exp_q = '{9'h166, 9'h199, 9'h106, 9'h031, 9'h102, 9'h005, 9'h100};
        check_log(0, "A_log0");
        repeat (20) @(negedge clk);
        check("TO_err1",   32'(init_error[1]), 32'd1);
        check("TO_done1",  32'(init_done[1]),  32'd0);
        check("TO_busy1",  32'(busy[1]),       32'd0);
        check("TO_valid1", 32'(cmd_valid[1]),  32'd0);
        exp_q = '{9'h166, 9'h199, 9'h106, 9'h031, 9'h102, 9'h005, 9'h100, 9'h005, 9'h100};
        check_log(1, "TO_log1");

        // Run B: backpressure on 0x31 and three busy polls on dut0
        wip_cfg[0] = 3;
        bp_cfg[0]  = 5;
        reset_release();
        wait_end(0, 600, "runB");
        check("B_bp_stable", 32'(bp_obs[0]), 32'd5);
        check("B_done0", 32'(init_done[0]),  32'd1);
        check("B_err0",  32'(init_error[0]), 32'd0);
        exp_q = '{9'h166, 9'h199, 9'h106, 9'h031, 9'h102,
                  9'h005, 9'h100, 9'h005, 9'h100, 9'h005, 9'h100, 9'h005, 9'h100};
        check_log(0, "B_log0");

        // Run C: reset asserted during the post-reset recovery wait
        wip_cfg[0] = 0;
        bp_cfg[0]  = 0;
        reset_release();
        begin
            int n = 0;
            while (log_n[0] < 2 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (log_n[0] < 2) check("C_reach_rst_wait", 32'(log_n[0]), 32'd2);
        end
        repeat (3) @(negedge clk);
        #1;
        check("C_busy_pre", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset(0, "C_async");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_end(0, 400, "runC");
        check("C_first_cyc", 32'(first_cyc[0]), 32'd4);
        check("C_done0", 32'(init_done[0]), 32'd1);
        exp_q = '{9'h166, 9'h199, 9'h106, 9'h031, 9'h102, 9'h005, 9'h100};
        check_log(0, "C_log0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
